key_lane_decoder: RTL and testbench

KEY_LANE_DECODER -- requirements
Module: key_lane_decoder

---
 rtl/key_lane_decoder.sv | 128 ++++++++++++
 tb/tb_key_lane_decoder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/key_lane_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : key_lane_decoder
// Purpose  : Maps raw keyboard keycodes (q/w/e/r) onto four rhythm-game lanes.
//            Produces a one-cycle press pulse, a held level, a saturating press
//            counter and a one-cycle bad_key pulse for unmapped keys.
// Options  : KEY_LANE_DEBOUNCE_EN - when defined, a key must be seen on
//            DEBOUNCE_FRAMES consecutive vsync edges before it is accepted.
//            When undefined, a key is accepted on its first sample.
// Revision : 1.0 - initial release
// ============================================================================
module key_lane_decoder #(
   parameter int DEBOUNCE_FRAMES = 2
) (
   input  logic        vsync,
   input  logic        reset_ah,
   input  logic [7:0]  keycode,
   output logic [3:0]  lane_press,
   output logic [3:0]  lane_held,
   output logic [15:0] press_count,
   output logic        bad_key
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_QUAL    = 2'd1,
      S_HELD    = 2'd2,
      S_INVALID = 2'd3
   } state_t;

   localparam logic [3:0] c_DEB = 4'(DEBOUNCE_FRAMES);
`ifdef KEY_LANE_DEBOUNCE_EN
   localparam logic c_DEB_EN = 1'b1;
`else
   localparam logic c_DEB_EN = 1'b0;
`endif
   // With a single-frame requirement qualification degenerates to direct acceptance.
   localparam logic c_DIRECT = !c_DEB_EN || (c_DEB <= 4'd1);

   state_t       r_state;
   logic [7:0]   r_cand;
   logic [3:0]   r_cnt;
   logic [3:0]   r_press;
   logic [3:0]   r_held;
   logic [15:0]  r_count;
   logic         r_bad;

   logic [3:0]   w_lane;
   logic         w_valid;
   logic         w_kc_zero;
   logic         w_new;
   logic         w_cnt_done;
   logic         w_accept;

   // Keycode to one-hot lane decode; all-zero means not a lane key.
   always_comb begin
      w_lane = 4'b0000;
      case (keycode)
         8'h14:   w_lane = 4'b0001;
         8'h1A:   w_lane = 4'b0010;
         8'h08:   w_lane = 4'b0100;
         8'h15:   w_lane = 4'b1000;
         default: w_lane = 4'b0000;
      endcase
   end

   // Classify the current sample: new candidate, qualification done, accepted now.
   always_comb begin
      w_valid    = |w_lane;
      w_kc_zero  = (keycode == 8'h00);
      w_new      = !w_kc_zero && ((r_state == S_IDLE) || (keycode != r_cand));
      w_cnt_done = ((r_cnt + 4'd1) >= c_DEB);
      w_accept   = w_new ? c_DIRECT
                         : ((r_state == S_QUAL) && !w_kc_zero && w_cnt_done);
   end

   // Main FSM with registered outputs; pulses default low every cycle.
   always_ff @(posedge vsync or posedge reset_ah) begin
      if (reset_ah) begin
         r_state <= S_IDLE;
         r_cand  <= 8'h00;
         r_cnt   <= 4'd0;
         r_press <= 4'b0000;
         r_held  <= 4'b0000;
         r_count <= 16'h0000;
         r_bad   <= 1'b0;
      end else begin
         r_press <= 4'b0000;
         r_bad   <= 1'b0;
         if (w_kc_zero) begin
            r_state <= S_IDLE;
            r_cand  <= 8'h00;
            r_cnt   <= 4'd0;
            r_held  <= 4'b0000;
         end else if (w_accept) begin
            r_cand <= keycode;
            r_cnt  <= 4'd0;
            if (w_valid) begin
               r_state <= S_HELD;
               r_press <= w_lane;
               r_held  <= w_lane;
               if (r_count != 16'hFFFF) begin
                  r_count <= r_count + 16'd1;
               end
            end else begin
               r_state <= S_INVALID;
               r_held  <= 4'b0000;
               r_bad   <= 1'b1;
            end
         end else if (w_new) begin
            r_state <= S_QUAL;
            r_cand  <= keycode;
            r_cnt   <= 4'd1;
            r_held  <= 4'b0000;
         end else if (r_state == S_QUAL) begin
            r_cnt <= r_cnt + 4'd1;
         end
      end
   end

   assign lane_press  = r_press;
   assign lane_held   = r_held;
   assign press_count = r_count;
   assign bad_key     = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_key_lane_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_key_lane_decoder
// Purpose  : Directed self-checking bench for key_lane_decoder, covering both
//            the debounced (KEY_LANE_DEBOUNCE_EN) and direct builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_lane_decoder;

   localparam int DEB = 2;
`ifdef KEY_LANE_DEBOUNCE_EN
   localparam int LAT = DEB;
`else
   localparam int LAT = 1;
`endif

   logic        vsync = 1'b0;
   logic        reset_ah;
   logic [7:0]  keycode;
   logic [3:0]  lane_press;
   logic [3:0]  lane_held;
   logic [15:0] press_count;
   logic        bad_key;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] exp_cnt;

   key_lane_decoder #(.DEBOUNCE_FRAMES(DEB)) dut (
      .vsync       (vsync),
      .reset_ah    (reset_ah),
      .keycode     (keycode),
      .lane_press  (lane_press),
      .lane_held   (lane_held),
      .press_count (press_count),
      .bad_key     (bad_key)
   );

   always #5 vsync = ~vsync;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a keycode, let one edge sample it, then settle past the edge.
   task automatic drive(input logic [7:0] kc);
      keycode = kc;
      @(posedge vsync);
      #1;
   endtask

   // Hold a key for a number of edges; lane==0 means an unmapped key.
   task automatic hold_key(input logic [7:0] kc, input int edges, input logic [3:0] lane);
      for (int i = 1; i <= edges; i++) begin
         drive(kc);
         check_eq("press", 16'(lane_press), (i == LAT) ? 16'(lane) : 16'h0);
         check_eq("held", 16'(lane_held), (i >= LAT) ? 16'(lane) : 16'h0);
         check_eq("bad_key", 16'(bad_key), (i == LAT && lane == 4'b0) ? 16'h1 : 16'h0);
         check_eq("held_onehot", 16'($countones(lane_held) <= 1), 16'h1);
      end
      if (lane != 4'b0 && edges >= LAT && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      check_eq("count", press_count, exp_cnt);
   endtask

   task automatic release_key();
      drive(8'h00);
      check_eq("rel_press", 16'(lane_press), 16'h0);
      check_eq("rel_held", 16'(lane_held), 16'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_cnt  = 16'h0000;
      reset_ah = 1'b1;
      keycode  = 8'h00;
      @(posedge vsync);
      @(posedge vsync);
      #1;
      check_eq("rst_press", 16'(lane_press), 16'h0);
      check_eq("rst_held", 16'(lane_held), 16'h0);
      check_eq("rst_count", press_count, 16'h0);
      check_eq("rst_bad", 16'(bad_key), 16'h0);
      reset_ah = 1'b0;

      // q held for 5 edges: single pulse, level until release
      hold_key(8'h14, 5, 4'b0001);
      release_key();

      // w for a single edge: rejected when debounced, accepted when direct
      hold_key(8'h1A, 1, 4'b0010);
      release_key();

      // e held, then straight to r: two pulses, never two-hot
      hold_key(8'h08, 3, 4'b0100);
      hold_key(8'h15, 3, 4'b1000);
      release_key();

      // unmapped key: one bad_key pulse, lanes and count untouched
      hold_key(8'h04, 4, 4'b0000);
      release_key();

      // reset while q is held clears everything at once, then re-qualifies
      hold_key(8'h14, LAT + 1, 4'b0001);
      #2;
      reset_ah = 1'b1;
      #1;
      exp_cnt = 16'h0000;
      check_eq("async_held", 16'(lane_held), 16'h0);
      check_eq("async_press", 16'(lane_press), 16'h0);
      check_eq("async_count", press_count, 16'h0);
      @(posedge vsync);
      #1;
      reset_ah = 1'b0;
      hold_key(8'h14, LAT + 1, 4'b0001);
      release_key();

      // shortcut to the saturation boundary instead of 65534 real presses
      dut.r_count = 16'hFFFE;
      exp_cnt     = 16'hFFFE;
      #1;
      check_eq("preload", press_count, 16'hFFFE);
      hold_key(8'h14, LAT, 4'b0001);
      release_key();
      hold_key(8'h1A, LAT, 4'b0010);
      release_key();
      check_eq("saturated", press_count, 16'hFFFF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
